// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage with request/ack data port, timeout and registered write-back record
`ifndef TRAP_STALL
`define TRAP_STALL 8'h01
`endif
`ifndef TRAP_ADDR_ERR
`define TRAP_ADDR_ERR 8'h02
`endif
`ifndef TRAP_BUS_ERR
`define TRAP_BUS_ERR 8'h03
`endif
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mem_op,
  input  logic [31:0] alu_val,
  input  logic [31:0] store_val,
  input  logic [4:0]  dest_reg,
  input  logic [7:0]  exception_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic [31:0] wb_val,
  output logic [4:0]  wb_reg,
  output logic        wb_enable,
  output logic [7:0]  exception,
  output logic        stall_req
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [2:0] op_q, op_n;
  logic [4:0] dest_q, dest_n;
  logic [1:0] off_q, off_n;
  logic [7:0] cnt_q, cnt_n;
  logic req_n, we_n, wb_en_n;
  logic [3:0] be_n;
  logic [31:0] addr_n, wdata_n, wb_val_n;
  logic [4:0] wb_reg_n;
  logic [7:0] exc_n;
  logic is_lw, is_sw, is_sb, is_mem;
  logic [7:0] rbyte;
  assign is_lw = mem_op == 3'd1;
  assign is_sw = mem_op == 3'd4;
  assign is_sb = mem_op == 3'd5;
  assign is_mem = mem_op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  assign rbyte = dmem_rdata[{off_q, 3'b000} +: 8];
  assign stall_req = state == WAIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0;
      dmem_addr  <= 32'b0;
      dmem_wdata <= 32'b0;
      wb_val     <= 32'b0;
      wb_reg     <= 5'b0;
      wb_enable  <= 1'b0;
      exception  <= `TRAP_STALL;
      cnt_q      <= 8'b0;
      op_q       <= 3'b0;
      dest_q     <= 5'b0;
      off_q      <= 2'b0;
    end else begin
      state      <= state_n;
      dmem_req   <= req_n;
      dmem_we    <= we_n;
      dmem_be    <= be_n;
      dmem_addr  <= addr_n;
      dmem_wdata <= wdata_n;
      wb_val     <= wb_val_n;
      wb_reg     <= wb_reg_n;
      wb_enable  <= wb_en_n;
      exception  <= exc_n;
      cnt_q      <= cnt_n;
      op_q       <= op_n;
      dest_q     <= dest_n;
      off_q      <= off_n;
    end
  end
  always_comb begin
    state_n  = state;
    req_n    = dmem_req;
    we_n     = dmem_we;
    be_n     = dmem_be;
    addr_n   = dmem_addr;
    wdata_n  = dmem_wdata;
    wb_val_n = 32'b0;
    wb_reg_n = 5'b0;
    wb_en_n  = 1'b0;
    exc_n    = 8'b0;
    cnt_n    = cnt_q;
    op_n     = op_q;
    dest_n   = dest_q;
    off_n    = off_q;
    if (state == IDLE) begin
      if (exception_in != 8'b0) begin
        exc_n = exception_in;
      end else if (!is_mem) begin
        wb_val_n = alu_val;
        wb_reg_n = dest_reg;
        wb_en_n  = dest_reg != 5'b0;
      end else if ((is_lw || is_sw) && alu_val[1:0] != 2'b0) begin
        exc_n = `TRAP_ADDR_ERR;
      end else begin
        op_n    = mem_op;
        dest_n  = dest_reg;
        off_n   = alu_val[1:0];
        req_n   = 1'b1;
        addr_n  = {alu_val[31:2], 2'b00};
        we_n    = is_sw || is_sb;
        be_n    = is_sb ? 4'b0001 << alu_val[1:0] : 4'b1111;
        wdata_n = is_sb ? {4{store_val[7:0]}} : store_val;
        cnt_n   = 8'b0;
        state_n = WAIT;
      end
    end else if (dmem_ack) begin
      req_n   = 1'b0;
      we_n    = 1'b0;
      be_n    = 4'b0;
      state_n = IDLE;
      if (op_q inside {3'd1, 3'd2, 3'd3}) begin
        wb_val_n = op_q == 3'd1 ? dmem_rdata :
                   op_q == 3'd2 ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
        wb_reg_n = dest_q;
        wb_en_n  = dest_q != 5'b0;
      end
    end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
      req_n   = 1'b0;
      we_n    = 1'b0;
      be_n    = 4'b0;
      exc_n   = `TRAP_BUS_ERR;
      state_n = IDLE;
    end else begin
      exc_n = `TRAP_STALL;
      cnt_n = cnt_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench; stimulus pushes expected per-cycle records, a negedge monitor pops and compares
`ifndef TRAP_STALL
`define TRAP_STALL 8'h01
`endif
`ifndef TRAP_ADDR_ERR
`define TRAP_ADDR_ERR 8'h02
`endif
`ifndef TRAP_BUS_ERR
`define TRAP_BUS_ERR 8'h03
`endif
module tb_mem_access;
  logic clk, rst;
  logic [2:0] mem_op;
  logic [31:0] alu_val, store_val, dmem_rdata, dmem_addr, dmem_wdata, wb_val;
  logic [4:0] dest_reg, wb_reg;
  logic [7:0] exception_in, exception;
  logic dmem_ack, dmem_req, dmem_we, wb_enable, stall_req;
  logic [3:0] dmem_be;
  typedef struct packed {
    logic [31:0] val;
    logic [4:0]  r;
    logic        en;
    logic [7:0]  exc;
    logic        stall;
    logic        req;
  } wb_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_t;
  typedef struct packed {
    wb_t  wb;
    logic chk;
    mem_t m;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  wb_t got_wb;
  mem_t got_m;
  int total = 0, bad = 0, idx = 0;
  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .alu_val(alu_val), .store_val(store_val),
    .dest_reg(dest_reg), .exception_in(exception_in), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .wb_val(wb_val), .wb_reg(wb_reg),
    .wb_enable(wb_enable), .exception(exception), .stall_req(stall_req)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got_wb = {wb_val, wb_reg, wb_enable, exception, stall_req, dmem_req};
      total++;
      if (got_wb !== e.wb) begin
        bad++;
        $display("FAIL wb_rec[%0d] got val=%h reg=%0d en=%b exc=%h stall=%b req=%b exp val=%h reg=%0d en=%b exc=%h stall=%b req=%b",
                 idx, got_wb.val, got_wb.r, got_wb.en, got_wb.exc, got_wb.stall, got_wb.req,
                 e.wb.val, e.wb.r, e.wb.en, e.wb.exc, e.wb.stall, e.wb.req);
      end
      if (e.chk) begin
        got_m = {dmem_addr, dmem_wdata, dmem_be, dmem_we};
        total++;
        if (got_m !== e.m) begin
          bad++;
          $display("FAIL mem_port[%0d] got addr=%h wdata=%h be=%b we=%b exp addr=%h wdata=%h be=%b we=%b",
                   idx, got_m.addr, got_m.wdata, got_m.be, got_m.we, e.m.addr, e.m.wdata, e.m.be, e.m.we);
        end
      end
      idx++;
    end
  end
  function automatic wb_t w(input logic [31:0] val, input logic [4:0] r, input logic en,
                            input logic [7:0] exc, input logic stall, input logic req);
    return {val, r, en, exc, stall, req};
  endfunction
  task automatic tick(input wb_t x);
    @(posedge clk);
    #1;
    sb.push_back({x, 1'b0, 69'b0});
  endtask
  task automatic tickm(input wb_t x, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic we);
    @(posedge clk);
    #1;
    sb.push_back({x, 1'b1, a, d, be, we});
  endtask
  task automatic set(input logic [2:0] op, input logic [31:0] a, input logic [31:0] s, input logic [4:0] d);
    mem_op = op;
    alu_val = a;
    store_val = s;
    dest_reg = d;
  endtask
  initial begin
    rst = 1'b1;
    set(3'd0, 32'h0, 32'h0, 5'd0);
    exception_in = 8'h0;
    dmem_rdata = 32'h0;
    dmem_ack = 1'b0;
    tickm(w(0, 0, 0, `TRAP_STALL, 0, 0), 32'h0, 32'h0, 4'b0, 1'b0);
    rst = 1'b0;
    set(3'd0, 32'h1234, 32'h0, 5'd5);
    tick(w(32'h1234, 5, 1, 0, 0, 0));
    set(3'd0, 32'h1234, 32'h0, 5'd0);
    tick(w(32'h1234, 0, 0, 0, 0, 0));
    set(3'd7, 32'h55, 32'h0, 5'd3);
    tick(w(32'h55, 3, 1, 0, 0, 0));
    set(3'd1, 32'h100, 32'h0, 5'd7);
    tickm(w(0, 0, 0, 0, 1, 1), 32'h100, 32'h0, 4'b1111, 1'b0);
    tick(w(0, 0, 0, `TRAP_STALL, 1, 1));
    tickm(w(0, 0, 0, `TRAP_STALL, 1, 1), 32'h100, 32'h0, 4'b1111, 1'b0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    tick(w(32'hDEADBEEF, 7, 1, 0, 0, 0));
    dmem_ack = 1'b0;
    set(3'd2, 32'h103, 32'h0, 5'd8);
    tick(w(0, 0, 0, 0, 1, 1));
    dmem_ack = 1'b1;
    dmem_rdata = 32'h80AABBCC;
    tick(w(32'hFFFFFF80, 8, 1, 0, 0, 0));
    dmem_ack = 1'b0;
    set(3'd3, 32'h103, 32'h0, 5'd8);
    tick(w(0, 0, 0, 0, 1, 1));
    dmem_ack = 1'b1;
    tick(w(32'h00000080, 8, 1, 0, 0, 0));
    dmem_ack = 1'b0;
    set(3'd2, 32'h101, 32'h0, 5'd9);
    tick(w(0, 0, 0, 0, 1, 1));
    dmem_ack = 1'b1;
    tick(w(32'hFFFFFFBB, 9, 1, 0, 0, 0));
    dmem_ack = 1'b0;
    set(3'd5, 32'h202, 32'h5A, 5'd4);
    tickm(w(0, 0, 0, 0, 1, 1), 32'h200, 32'h5A5A5A5A, 4'b0100, 1'b1);
    tickm(w(0, 0, 0, `TRAP_STALL, 1, 1), 32'h200, 32'h5A5A5A5A, 4'b0100, 1'b1);
    dmem_ack = 1'b1;
    tick(w(0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b0;
    set(3'd4, 32'h300, 32'h11223344, 5'd4);
    tickm(w(0, 0, 0, 0, 1, 1), 32'h300, 32'h11223344, 4'b1111, 1'b1);
    dmem_ack = 1'b1;
    tick(w(0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b0;
    set(3'd1, 32'h102, 32'h0, 5'd7);
    tick(w(0, 0, 0, `TRAP_ADDR_ERR, 0, 0));
    set(3'd4, 32'h301, 32'h0, 5'd0);
    tick(w(0, 0, 0, `TRAP_ADDR_ERR, 0, 0));
    set(3'd1, 32'h100, 32'h0, 5'd7);
    exception_in = 8'h07;
    tick(w(0, 0, 0, 8'h07, 0, 0));
    exception_in = 8'h00;
    set(3'd1, 32'h400, 32'h0, 5'd6);
    tick(w(0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++) tick(w(0, 0, 0, `TRAP_STALL, 1, 1));
    tick(w(0, 0, 0, `TRAP_BUS_ERR, 0, 0));
    set(3'd1, 32'h500, 32'h0, 5'd2);
    tick(w(0, 0, 0, 0, 1, 1));
    rst = 1'b1;
    tickm(w(0, 0, 0, `TRAP_STALL, 0, 0), 32'h0, 32'h0, 4'b0, 1'b0);
    rst = 1'b0;
    set(3'd0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF;
    tick(w(0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b0;
    set(3'd0, 32'hCAFE, 32'h0, 5'd31);
    tick(w(32'hCAFE, 31, 1, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d left required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
